fibonacci_checker: RTL

Request-side consumer and self-checker for the fibonacci generator. On start it issues N single-cycle f_en requests, one outstanding at a time. It compares each f_valid/f_out response against an internal Fibonacci model of the same width, then reports pass/fail, an error count, the first failing term and the last received value. It sits beside the generator in the same clock/reset domain, for on-chip self-test and bench reuse.

---
 rtl/fibonacci_checker.sv | 110 +++++++++++
 1 files changed

// File: rtl/fibonacci_checker.sv
// fibonacci_checker: issues one-at-a-time requests to a fibonacci generator and checks each response
// against an internal modulo-2^WIDTH Fibonacci model, reporting pass/fail, error count and first error.
module fibonacci_checker #(
  parameter int WIDTH   = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             f_en,
  input  logic             f_valid,
  input  logic [WIDTH-1:0] f_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             spurious,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] last_value
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a, b;
  logic [CNT_W-1:0] n, idx, err_inc, first_upd;
  logic [TW-1:0]    wcnt;
  assign err_inc   = &err_count ? err_count : err_count + 1'b1;
  assign first_upd = first_err_idx == '0 ? idx : first_err_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      f_en          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      spurious      <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      last_value    <= '0;
      a             <= '0;
      b             <= WIDTH'(1);
      n             <= '0;
      idx           <= '0;
      wcnt          <= '0;
    end else begin
      f_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          err_count     <= '0;
          first_err_idx <= '0;
          timeout       <= 1'b0;
          spurious      <= 1'b0;
          pass          <= 1'b0;
          n             <= num_terms;
          idx           <= CNT_W'(1);
          if (num_terms != '0) begin
            state <= REQ;
            f_en  <= 1'b1;
            busy  <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        REQ: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: if (f_valid) begin
          last_value <= f_out;
          if (f_out != b) begin
            err_count     <= err_inc;
            first_err_idx <= first_upd;
          end
          // advance on the expected value so one corrupt term costs exactly one error
          a <= b;
          b <= a + b;
          if (idx == n) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            state <= REQ;
            f_en  <= 1'b1;
          end
        end else if (wcnt == TW'(TIMEOUT - 1)) begin
          timeout       <= 1'b1;
          err_count     <= err_inc;
          first_err_idx <= first_upd;
          state         <= DONE;
          done          <= 1'b1;
          busy          <= 1'b0;
        end else wcnt <= wcnt + 1'b1;
        DONE: begin
          pass  <= err_count == '0 && !timeout && !spurious;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // placed after the case so a response arriving with start still registers after the clear
      if (state != WAIT && f_valid) spurious <= 1'b1;
    end
  end
endmodule
